// File: rtl/word_bus_arbiter.sv
// word_bus_arbiter: round-robin arbiter and sequencer for one shared word bus.
// Grants one of four requesters at a time, drives the mux select, forwards the
// granted word with a valid/ready handshake and bounds each grant to MAX_BURST
// transfers before rotating priority.
module word_bus_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [0:3]       i_req,
    input  logic [0:WIDTH-1] i_data0,
    input  logic [0:WIDTH-1] i_data1,
    input  logic [0:WIDTH-1] i_data2,
    input  logic [0:WIDTH-1] i_data3,
    input  logic             i_ready,
    output logic [0:3]       o_gnt,
    output logic [0:1]       o_sel,
    output logic [0:WIDTH-1] o_data,
    output logic             o_valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Count value at which the next transfer closes the burst.
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    logic [0:0] state;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [3:0] count;

    logic busy;
    logic any_req;
    logic xfer;
    logic release_grant;

    // First requester found scanning base, base+1, base+2, base+3 (mod 4).
    function automatic logic [1:0] pick(input logic [1:0] base, input logic [0:3] req);
        logic [1:0] idx;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign busy          = (state == BUSY);
    assign any_req       = |i_req;
    assign o_valid       = busy && i_req[owner];
    assign xfer          = o_valid && i_ready;
    // The owner lets go when it stops requesting or completes its last allowed beat.
    assign release_grant = busy && (!i_req[owner] || (xfer && count == LAST_BEAT));
    assign o_sel         = owner;

    // One-hot grant at the owner while busy, all zero when idle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        o_gnt = 4'b0000;
        if (busy) o_gnt[owner] = 1'b1;
    end

    // Word multiplexer steered by the current (or last) owner.
    always_comb begin
        o_data = i_data0;
        case (owner)
            2'd1:    o_data = i_data1;
            2'd2:    o_data = i_data2;
            2'd3:    o_data = i_data3;
            default: o_data = i_data0;
        endcase
    end

    // Grant FSM: arbitration, burst counting and back-to-back handover.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching the hardware.
        if (i_rst) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd0;
            count <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= pick(ptr, i_req);
                        count <= 4'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_grant) begin
                        ptr <= owner + 2'd1;
                        if (any_req) begin
                            // A still-requesting owner is scanned last, so it only wins when alone.
                            owner <= pick(owner + 2'd1, i_req);
                            count <= 4'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        count <= count + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_bus_arbiter.sv
// tb_word_bus_arbiter: directed self-checking bench for word_bus_arbiter.
module tb_word_bus_arbiter;

    localparam int WIDTH = 16;

    logic             i_clk;
    logic             i_rst;
    logic [0:3]       i_req;
    logic [0:WIDTH-1] i_data0, i_data1, i_data2, i_data3;
    logic             i_ready;
    logic [0:3]       o_gnt;
    logic [0:1]       o_sel;
    logic [0:WIDTH-1] o_data;
    logic             o_valid;

    int checks = 0;
    int errors = 0;

    logic [15:0] words [4];

    word_bus_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_data0 (i_data0),
        .i_data1 (i_data1),
        .i_data2 (i_data2),
        .i_data3 (i_data3),
        .i_ready (i_ready),
        .o_gnt   (o_gnt),
        .o_sel   (o_sel),
        .o_data  (o_data),
        .o_valid (o_valid)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] v;
        v = 4'b1000 >> k;
        return v;
    endfunction

    task automatic check_grant(input string tag, input int k);
        check({tag, "_gnt"},   32'(o_gnt),   32'(onehot(k)));
        check({tag, "_sel"},   32'(o_sel),   32'(k));
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_data"},  32'(o_data),  32'(words[k]));
    endtask

    initial begin
        words[0] = 16'hA000;
        words[1] = 16'hB111;
        words[2] = 16'hC222;
        words[3] = 16'hD333;
        i_data0 = words[0];
        i_data1 = words[1];
        i_data2 = words[2];
        i_data3 = words[3];
        i_rst   = 1'b1;
        i_req   = 4'b0000;
        i_ready = 1'b0;

        // Reset state.
        #3;
        check("rst_gnt",   32'(o_gnt),   32'h0);
        check("rst_sel",   32'(o_sel),   32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_data",  32'(o_data),  32'(words[0]));
        tick();
        #2 i_rst = 1'b0;

        // Single requester 1: grant after one edge, re-granted after 4 beats with no gap.
        i_req   = 4'b0100;
        i_ready = 1'b1;
        tick();
        check_grant("solo_first", 1);
        check("solo_count0", 32'(dut.count), 32'd0);
        for (int c = 1; c < 4; c++) begin
            tick();
            check_grant("solo_beat", 1);
            check("solo_count", 32'(dut.count), 32'(c));
        end
        tick();
        check_grant("solo_regrant", 1);
        check("solo_regrant_count", 32'(dut.count), 32'd0);

        // All requests drop: valid falls at once, next edge goes idle with sel held.
        i_req = 4'b0000;
        #1;
        check("drop_valid_now", 32'(o_valid), 32'd0);
        tick();
        check("idle_gnt",   32'(o_gnt),   32'h0);
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_sel",   32'(o_sel),   32'd1);
        check("idle_data",  32'(o_data),  32'(words[1]));

        // Fresh reset, then all four requesting: order 0,1,2,3,0 with 4 beats each.
        #2 i_rst = 1'b1;
        tick();
        #2 i_rst = 1'b0;
        i_req = 4'b1111;
        for (int g = 0; g < 20; g++) begin
            tick();
            check_grant("rr", (g / 4) % 4);
        end

        // Only requester 2 left: owner 0 releases and 2 is granted next.
        i_req = 4'b0010;
        tick();
        check_grant("stall_start", 2);
        i_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_grant("stall_hold", 2);
            check("stall_count", 32'(dut.count), 32'd0);
        end
        // Ready returns with requester 3 waiting: four more beats, then handover.
        i_ready = 1'b1;
        i_req   = 4'b0011;
        #1;
        check_grant("resume_beat0", 2);
        for (int b = 1; b < 4; b++) begin
            tick();
            check_grant("resume_beat", 2);
        end
        tick();
        check_grant("stall_handover", 3);

        // Move ownership to 0, then 0 drops after 2 transfers while 3 waits.
        i_req = 4'b1000;
        tick();
        check_grant("own0", 0);
        i_req = 4'b1001;
        tick();
        tick();
        check("own0_count2", 32'(dut.count), 32'd2);
        i_req = 4'b0001;
        #1;
        check("own0_drop_valid", 32'(o_valid), 32'd0);
        check("own0_drop_gnt",   32'(o_gnt),   32'(onehot(0)));
        tick();
        check_grant("drop_handover", 3);
        check("drop_ptr", 32'(dut.ptr), 32'd1);

        // Asynchronous reset mid-burst (owner 3, count 2).
        tick();
        tick();
        check("mid_count2", 32'(dut.count), 32'd2);
        #2 i_rst = 1'b1;
        i_req = 4'b1001;
        #1;
        check("async_gnt",   32'(o_gnt),   32'h0);
        check("async_valid", 32'(o_valid), 32'd0);
        check("async_sel",   32'(o_sel),   32'd0);
        check("async_data",  32'(o_data),  32'(words[0]));
        tick();
        #2 i_rst = 1'b0;
        tick();
        check_grant("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_bus_arbiter.md
# word_bus_arbiter

Round-robin arbiter and sequencer for one shared word bus fed by four requesters through a 4-way word multiplexer. It grants the bus to one requester at a time and drives the mux select. It also forwards the granted requester's word downstream with a valid/ready handshake and bounds each grant to a maximum burst of transfers. It sits between the requester ports and the single downstream word consumer.

## Interface

- `WIDTH`, default 16: data word width, bits numbered `[0:WIDTH-1]`, bit 0 MSB.
- `MAX_BURST`, default 4: maximum transfers per grant before forced rotation. Legal range is 1..15.

- `i_clk`, input, 1: the block's one clock; all state changes on the rising edge.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_req`, input, `[0:3]`: request per requester; `i_req[k]` held high while requester k has words to send.
- `i_data0`..`i_data3`, input, `[0:WIDTH-1]` each: word offered by each requester.
- `i_ready`, input, 1: downstream accepts `o_data` this cycle.
- `o_gnt`, output, `[0:3]`: one-hot grant, or all zero when idle.
- `o_sel`, output, `[0:1]`: mux select, the binary index of the current/last owner.
- `o_data`, output, `[0:WIDTH-1]`: the word from `i_data[o_sel]`, combinational.
- `o_valid`, output, 1: `o_data` is a valid word from the granted requester.

## Operation

- State: FSM `{IDLE, BUSY}`, `owner[0:1]`, `ptr[0:1]` (highest-priority index), `count` (transfers in the current grant, 4 bits).
- Transfer occurs in a cycle where `o_valid && i_ready`.
- Arbitration function `pick(base)`: scan indices `base, base+1, base+2, base+3` (mod 4) and pick the first with `i_req` high.
- IDLE:
  - `o_gnt = 0` and `o_valid = 0`.
  - If any `i_req` is high, register `owner = pick(ptr)`, clear `count`, and go to BUSY.
- BUSY:
  - `o_gnt` is one-hot at `owner`.
  - `o_valid = i_req[owner]`.
  - On each transfer, `count` increments by 1.
- Release happens in BUSY when either:
  - `i_req[owner]` is 0, or
  - a transfer occurs with `count == MAX_BURST-1`.
- On release:
  - `ptr = owner+1` (wraps 3 to 0).
  - If any `i_req` is high this cycle, register `owner = pick(owner+1)`, clear `count`, and stay in BUSY. This gives a back-to-back grant with no idle cycle.
  - Otherwise go to IDLE.
- A burst-limited owner that is still requesting competes at lowest priority. If it is the only requester, it is re-granted with `count` cleared.
- `o_sel` always equals `owner`. It holds its value through IDLE. `o_data` is always the word at index `o_sel`.
- A requester must not change `i_data[k]` while granted, valid, and `i_ready` is low. The block does not check this.

## Timing

- Reset (asynchronous, immediate) gives:
  - state IDLE, `ptr = 0`, `owner = 0`, `count = 0`;
  - `o_gnt = 0000`, `o_sel = 00`, `o_valid = 0`;
  - `o_data = i_data0`.
- Reset asserted mid-burst drops `o_gnt` and `o_valid` in the same instant. No transfer completes in that cycle.
- Grant latency: `i_req` rises in IDLE at edge N, and `o_gnt`/`o_valid` are high after edge N+1.
- Handover latency: the release cycle is the last cycle of the old grant. The new grant is visible after the next edge.
- `o_valid` follows `i_req[owner]` combinationally within a grant.
- Throughput: 1 word/cycle while `i_ready` is high, with no bubble between bursts when other requesters are waiting.
- A requester that drops `i_req` and raises it again while owner is handled as follows:
  - The cycle where it is low is a release.
  - When it rises again, it is arbitrated like any other request.

## Test plan

- Reset, then `i_req = 0100` and `i_ready = 1` held: after 1 edge `o_gnt = 0100`, `o_sel = 01`, `o_valid = 1`, `o_data = i_data1`. After 4 transfers, requester 1 is re-granted with `count = 0` and there is no gap.
- `i_req = 1111`, `i_ready = 1`, `MAX_BURST = 4`: the grant order is 0, 1, 2, 3, 0. Each grant lasts exactly 4 cycles, with zero idle cycles between grants.
- Owner 2 with `i_ready = 0` for 3 cycles: `o_valid` stays high, `count` does not advance, `o_data = i_data2` is stable, and the grant is held. The burst ends 4 transfers after `i_ready` rises.
- Owner 0 drops `i_req` after 2 transfers while `i_req[3] = 1`: `o_valid = 0` in the drop cycle, `o_gnt = 0001` on the next edge, and `ptr = 1`.
- All requests drop: after the release edge `o_gnt = 0000` and `o_valid = 0`, and `o_sel` keeps the last owner.
- Assert `i_rst` asynchronously mid-burst (owner 3, `count = 2`): outputs drop to their reset values before the next edge. After release with `i_req = 1001`, requester 0 is granted first.
